// File: rtl/regfile_pkg.sv
// Shared definitions for the LC-3 register file write arbiter.
//   DATA_W / ADDR_W / NUM_REGS : register width, select width, register count
//   state_t                    : arbiter FSM states (sweep, normal operation)
//   NZP_*                      : one-hot condition code values {N,Z,P}
//   nzp_of()                   : condition codes produced by a written value
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Select of the last register touched by the post-reset clear sweep.
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    // Two's-complement sign decides N first; otherwise zero vs positive.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] value);
        if (value[DATA_W-1])
            return NZP_N;
        else if (value == '0)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request ports and the register file write port.
//   valid0/ready0/dr0/data0/setcc0 : port 0 (ALU/execute) request handshake
//   valid1/ready1/dr1/data1/setcc1 : port 1 (memory load) request handshake
//   wr_en/wr_addr/wr_data          : registered register file write port
//   nzp                            : registered condition codes {N,Z,P}
//   init_done                      : clear sweep finished
// Modports: master = requesters / register file side, slave = arbiter.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic              valid0;
    logic              ready0;
    logic [ADDR_W-1:0] dr0;
    logic [DATA_W-1:0] data0;
    logic              setcc0;

    logic              valid1;
    logic              ready1;
    logic [ADDR_W-1:0] dr1;
    logic [DATA_W-1:0] data1;
    logic              setcc1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        nzp;
    logic              init_done;

    modport master (
        output valid0, dr0, data0, setcc0,
        output valid1, dr1, data1, setcc1,
        input  ready0, ready1,
        input  wr_en, wr_addr, wr_data, nzp, init_done
    );

    modport slave (
        input  valid0, dr0, data0, setcc0,
        input  valid1, dr1, data1, setcc1,
        output ready0, ready1,
        output wr_en, wr_addr, wr_data, nzp, init_done
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way grant.
//   valid : {port1, port0} request vector
//   ptr   : round-robin pointer, names the port favoured on a tie
//   grant : one-hot {port1, port0} grant (zero when nothing is valid)
// RR_EN = 0 turns the tie-break into fixed priority with port 1 winning.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = (RR_EN && !ptr) ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the single write port of the 8 x 16-bit LC-3 register file.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of regfile_write_arbiter_if (request ports, write
//           port, condition codes, init_done)
// After reset an optional sweep writes zero to R0..R7, then requests from
// the two writeback ports are accepted one per cycle and written with a
// latency of one clock. NZP follows every accepted write that asks for it.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter bit INIT_CLEAR = 1'b1,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);

    localparam state_t RESET_STATE = INIT_CLEAR ? INIT : RUN;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] sweep_q,     sweep_d;
    logic              ptr_q,       ptr_d;
    logic              init_done_q, init_done_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [2:0]        nzp_q,       nzp_d;

    logic [1:0] grant;
    logic       accepting;
    logic       xfer0;
    logic       xfer1;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .valid ({bus.valid1, bus.valid0}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Requests are only taken in RUN and never while reset is held, so a
    // request presented during reset is dropped rather than half-accepted.
    assign accepting  = (state_q == RUN) && !reset;
    assign bus.ready0 = accepting && grant[0];
    assign bus.ready1 = accepting && grant[1];
    assign xfer0      = bus.valid0 && bus.ready0;
    assign xfer1      = bus.valid1 && bus.ready1;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        nzp_d       = nzp_q;

        case (state_q)
            INIT: begin
                // Sweep writes never touch the condition codes.
                wr_en_d   = 1'b1;
                wr_addr_d = sweep_q;
                wr_data_d = '0;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LAST_REG) begin
                    init_done_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (xfer0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = bus.dr0;
                    wr_data_d = bus.data0;
                    ptr_d     = 1'b1;
                    if (bus.setcc0)
                        nzp_d = nzp_of(bus.data0);
                end else if (xfer1) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = bus.dr1;
                    wr_data_d = bus.data1;
                    ptr_d     = 1'b0;
                    if (bus.setcc1)
                        nzp_d = nzp_of(bus.data1);
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            sweep_q     <= '0;
            ptr_q       <= 1'b0;
            init_done_q <= ~INIT_CLEAR;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            nzp_q       <= NZP_Z;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            nzp_q       <= nzp_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.nzp       = nzp_q;
    assign bus.init_done = init_done_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name:
regfile_write_arbiter

Overview:
- Owns the single write port of the 8 x 16-bit LC-3 register file.
- Arbitrates two writeback requesters over valid/ready handshakes: port 0 (ALU/execute) and port 1 (memory load).
- Drives the write enable, destination select (into the 3-to-8 destination decoder) and write data.
- Maintains the NZP condition codes. After reset, optionally sweeps R0..R7 to zero before accepting requests.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 3, register select width (NUM_REGS = 2**ADDR_W)
INIT_CLEAR, 1, 1 = zero all registers after reset; 0 = skip sweep
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 1 wins

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
valid0  input  1  port 0 request
ready0  output  1  port 0 accepted this cycle (combinational)
dr0  input  ADDR_W  port 0 destination register
data0  input  DATA_W  port 0 write data
setcc0  input  1  port 0 write updates NZP
valid1  input  1  port 1 request
ready1  output  1  port 1 accepted this cycle (combinational)
dr1  input  ADDR_W  port 1 destination register
data1  input  DATA_W  port 1 write data
setcc1  input  1  port 1 write updates NZP
wr_en  output  1  register file load enable (registered)
wr_addr  output  ADDR_W  destination select to decoder (registered)
wr_data  output  DATA_W  write data (registered)
nzp  output  3  condition codes {N,Z,P} (registered)
init_done  output  1  clear sweep complete; requests may be accepted

Behaviour:
Reset values:
- wr_en=0, wr_addr=0, wr_data=0, nzp=3'b010.
- init_done=0 when INIT_CLEAR=1, 1 when INIT_CLEAR=0.
- RR pointer=0, sweep count=0.
- ready0 and ready1 are 0 while reset is high.

States (2):
- INIT (entered on reset when INIT_CLEAR=1): on the k-th edge with reset low (k=1..8), register wr_en=1, wr_addr=k-1, wr_data=0.
- INIT, edge 8: also sets init_done=1 and moves to RUN. ready0/ready1 stay 0 throughout INIT.
- RUN (entered directly on reset when INIT_CLEAR=0):
  - Exactly one accepted request per cycle; ready_i = grant_i.
  - A transfer occurs when valid_i & ready_i.
  - Next edge registers wr_en=1, wr_addr=dr_i, wr_data=data_i (latency 1).
  - No transfer: wr_en=0 next edge; wr_addr and wr_data hold.
- Arbitration:
  - Only one valid: grant it.
  - Both valid, RR_EN=1: grant the port the pointer names. After any grant, pointer = the other port.
  - Both valid, RR_EN=0: grant port 1.
- Handshake rule: a requester keeps valid and its payload stable until accepted. ready never depends on the requester's own ready.
- NZP: on the same edge as an accepted write with setcc_i=1:
  - N=data[DATA_W-1]
  - Z=(data==0)
  - P=otherwise
  - Exactly one bit is set. setcc=0 or a sweep write leaves nzp unchanged.
- Same dr on both ports in one cycle: both writes occur, serialized. The later grant's data is the final register content.
- Reset mid-INIT or mid-RUN: next edge restores all reset values; any pending request is dropped and the sweep restarts at R0.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS, state encoding {INIT, RUN}, NZP constants (N=3'b100, Z=3'b010, P=3'b001).
- One sub-module rr_arb2: combinational 2-way grant given valid pair, pointer and RR_EN.
- Pointer register, FSM, NZP logic and output registers stay in the top module.

Test Plan:
- Reset 2 cycles, INIT_CLEAR=1 -> wr_en=1 for 8 consecutive cycles, wr_addr 0..7, wr_data 0x0000. init_done=1 after the 8th edge. ready0/ready1=0 throughout, nzp=010.
- RUN, valid0 only, dr0=3, data0=0x8001, setcc0=1 -> ready0=1 same cycle. Next cycle wr_en=1, wr_addr=3, wr_data=0x8001, nzp=100.
- Pointer=0, both valid, dr=5, data0=0x0000, data1=0x0007, both setcc -> cycle 1: write 0x0000, nzp=010, ready1=0. Cycle 2: write 0x0007, nzp=001.
- RR_EN=1, both valid held across 4 transfers -> grants alternate 0,1,0,1. With RR_EN=0 -> port 1 every cycle until valid1 drops.
- valid1, data1=0xFFFF, setcc1=0, prior nzp=001 -> write occurs, nzp stays 001.
- Reset asserted for 1 cycle at the 4th sweep write -> wr_en=0 next cycle. Sweep restarts at wr_addr=0, init_done=0 until 8 writes complete.
